memory_writeback_stage: RTL and testbench
=========================================

Name: memory_writeback_stage

Overview:
Final pipeline stage. It accepts one executed instruction per handshake, performs the optional data-memory load or store over a req/ack interface, and drives the writeback bus that the decode stage consumes. That bus is writeback_regwrite, writeback_writeaddr, writeback_writedata, writeback_setflags and writeback_flags. It stalls the upstream pipeline while a memory access is outstanding and latches a sticky fault if memory never answers.

Parameters:
MEM_TIMEOUT, 255, maximum cycles in MEM_WAIT without mem_ack before entering FAULT (legal range 1..65535).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
ex_valid  in  1  execute stage presents an instruction
ex_result  in  64  ALU result; doubles as memory address for loads/stores
ex_store_data  in  64  store data
ex_flags  in  4  ALU flags
ex_write_addr  in  5  destination register
ex_regwrite  in  1  instruction writes a register
ex_memwrite  in  1  store
ex_memtoreg  in  1  load
ex_setflags  in  1  instruction updates flags
stall  out  1  upstream must hold ex_* stable and not advance
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  64  memory address
mem_wdata  out  64  store data
mem_rdata  in  64  load data, valid with mem_ack
mem_ack  in  1  memory completes request
writeback_regwrite  out  1  one-cycle register write strobe
writeback_writeaddr  out  5  register write address
writeback_writedata  out  64  register write data
writeback_setflags  out  1  one-cycle flags write strobe
writeback_flags  out  4  flags value
mem_fault  out  1  sticky memory-timeout indicator

Behaviour:
- Reset is synchronous: rst=0 at a rising edge takes effect at that edge.
- Reset values:
  - state = IDLE; every output = 0; timeout counter = 0.
  - Reset mid-access abandons the transaction; any later mem_ack is ignored.
- States: IDLE, MEM_WAIT, FAULT.
- stall = 1 in MEM_WAIT and FAULT, 0 in IDLE (combinational from state).
- An instruction is accepted at an edge where state = IDLE and ex_valid = 1.
- IDLE, accepted, no memory op (ex_memwrite = 0 and ex_memtoreg = 0):
  - Writeback registers load at that edge; visible the following cycle (1-cycle latency).
  - writeback_regwrite = ex_regwrite; writeback_setflags = ex_setflags.
  - writeback_writedata = ex_result; writeback_writeaddr and writeback_flags = ex_* values.
  - Stays in IDLE; back-to-back accepts give one writeback per cycle.
- IDLE, accepted, memory op:
  - Latch write_addr, regwrite, setflags, flags and memtoreg into the capture register.
  - mem_req is registered to 1; mem_addr = ex_result; mem_wdata = ex_store_data.
  - mem_we = ex_memwrite; go to MEM_WAIT.
  - If both ex_memwrite and ex_memtoreg are set, the store wins and the latched regwrite is forced to 0.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - The counter increments each cycle without mem_ack.
- MEM_WAIT, mem_ack = 1 at an edge:
  - mem_req drops to 0 at that edge; state goes to IDLE; counter clears.
  - Writeback registers load from the capture register.
  - writeback_writedata = mem_rdata for a load, or 0 for a store.
  - A store's regwrite strobe is 0; a store's setflags strobe is as latched.
  - Writeback is visible the cycle after the ack edge.
  - Minimum load latency: accept edge to writeback visible = 2 cycles, with ack on the first MEM_WAIT cycle.
- mem_ack while not in MEM_WAIT: ignored.
- Timeout: counter reaches MEM_TIMEOUT with no ack → FAULT.
  - mem_req = 0; mem_fault = 1; stall = 1; no writeback.
  - FAULT is left only by reset.
  - Ack on the same edge the counter hits the limit: the ack wins.
- Strobe and field rules:
  - writeback_regwrite and writeback_setflags are single-cycle pulses. They are 0 in every cycle without a newly completed instruction.
  - writeback_writeaddr, writeback_writedata and writeback_flags hold their last value when not strobed.
  - Register 0 writes are passed through unchanged; the register file owns their semantics.

Decomposition:
- Shared package (header):
  - typedef enum wb_state_t {WB_IDLE, WB_MEM_WAIT, WB_FAULT}.
  - Constants DATA_W = 64, REG_ADDR_W = 5, FLAGS_W = 4.
  - Packed struct wb_bus_t {regwrite, writeaddr, writedata, setflags, flags}. The decode stage reuses it.
- Sub-module wb_timeout_counter, parameterised by MEM_TIMEOUT:
  - inputs clear and enable; output expired.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with ex_valid = 1 → all outputs 0, stall = 0, no mem_req. Release rst → first accept behaves normally.
- ALU op: ex_result = 64'h1234, ex_write_addr = 7, ex_regwrite = 1, ex_setflags = 1, ex_flags = 4'b1010 → next cycle writeback_regwrite = 1, writeaddr = 7, writedata = 64'h1234, setflags = 1, flags = 4'b1010. Strobes are 0 the cycle after.
- Load with 3-cycle ack delay, ex_result = 64'h100, ex_write_addr = 3:
  - mem_req = 1, mem_we = 0, mem_addr = 64'h100 and stall = 1 until ack.
  - mem_rdata = 64'hDEAD_BEEF with ack → next cycle regwrite = 1, writeaddr = 3, writedata = 64'hDEAD_BEEF; stall = 0.
- Store, ex_result = 64'h200, ex_store_data = 64'h55: mem_we = 1, mem_wdata = 64'h55 held until ack → after ack, regwrite strobe = 0.
- Timeout with MEM_TIMEOUT = 4, no ack:
  - after 4 MEM_WAIT cycles: mem_fault = 1, mem_req = 0, stall = 1 stays set.
  - a late ack has no effect; rst clears the fault.
- Reset mid-load, then ack: assert rst during MEM_WAIT, then ack the cycle after release → ack ignored, no writeback, state IDLE.

Source files
------------

// File: rtl/memory_writeback_stage_pkg.sv
// rtl/memory_writeback_stage_pkg.sv - shared types and widths for the memory/writeback stage
package memory_writeback_stage_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int FLAGS_W    = 4;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_MEM_WAIT,
        WB_FAULT
    } wb_state_t;

    typedef struct packed {
        logic                  regwrite;
        logic [REG_ADDR_W-1:0] writeaddr;
        logic [DATA_W-1:0]     writedata;
        logic                  setflags;
        logic [FLAGS_W-1:0]    flags;
    } wb_bus_t;

    // Instruction fields parked while a memory access is in flight
    typedef struct packed {
        logic                  regwrite;
        logic                  setflags;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] writeaddr;
        logic [FLAGS_W-1:0]    flags;
    } wb_capture_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - counts unanswered memory-wait cycles and flags expiry
module wb_timeout_counter #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (enable && (count != 16'(MEM_TIMEOUT))) begin
            count <= count + 16'd1;
        end
    end

    // Expiry is seen one cycle early so the edge that would reach the limit is the edge that faults
    assign expired = enable && (count == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/memory_writeback_stage.sv
// rtl/memory_writeback_stage.sv - final pipeline stage: optional data-memory access and writeback bus
module memory_writeback_stage
    import memory_writeback_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [FLAGS_W-1:0]    ex_flags,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    input  logic                  ex_regwrite,
    input  logic                  ex_memwrite,
    input  logic                  ex_memtoreg,
    input  logic                  ex_setflags,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  writeback_regwrite,
    output logic [REG_ADDR_W-1:0] writeback_writeaddr,
    output logic [DATA_W-1:0]     writeback_writedata,
    output logic                  writeback_setflags,
    output logic [FLAGS_W-1:0]    writeback_flags,
    output logic                  mem_fault
);

    wb_state_t   state;
    wb_bus_t     wb_q;
    wb_capture_t cap_q;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    assign tmo_enable = (state == WB_MEM_WAIT) && !mem_ack;
    assign tmo_clear  = (state != WB_MEM_WAIT) || mem_ack;

    wb_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WB_IDLE;
            wb_q      <= '0;
            cap_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_fault <= 1'b0;
        end else begin
            wb_q.regwrite <= 1'b0;
            wb_q.setflags <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (ex_valid) begin
                        if (ex_memwrite || ex_memtoreg) begin
                            // A store never writes a register, even if memtoreg is also set
                            cap_q.regwrite  <= ex_regwrite && !ex_memwrite;
                            cap_q.setflags  <= ex_setflags;
                            cap_q.memtoreg  <= ex_memtoreg && !ex_memwrite;
                            cap_q.writeaddr <= ex_write_addr;
                            cap_q.flags     <= ex_flags;
                            mem_req         <= 1'b1;
                            mem_we          <= ex_memwrite;
                            mem_addr        <= ex_result;
                            mem_wdata       <= ex_store_data;
                            state           <= WB_MEM_WAIT;
                        end else begin
                            wb_q.regwrite  <= ex_regwrite;
                            wb_q.writeaddr <= ex_write_addr;
                            wb_q.writedata <= ex_result;
                            wb_q.setflags  <= ex_setflags;
                            wb_q.flags     <= ex_flags;
                        end
                    end
                end
                WB_MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req        <= 1'b0;
                        state          <= WB_IDLE;
                        wb_q.regwrite  <= cap_q.regwrite;
                        wb_q.writeaddr <= cap_q.writeaddr;
                        wb_q.writedata <= cap_q.memtoreg ? mem_rdata : '0;
                        wb_q.setflags  <= cap_q.setflags;
                        wb_q.flags     <= cap_q.flags;
                    end else if (tmo_expired) begin
                        mem_req   <= 1'b0;
                        mem_fault <= 1'b1;
                        state     <= WB_FAULT;
                    end
                end
                WB_FAULT: begin
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign stall               = (state != WB_IDLE);
    assign writeback_regwrite  = wb_q.regwrite;
    assign writeback_writeaddr = wb_q.writeaddr;
    assign writeback_writedata = wb_q.writedata;
    assign writeback_setflags  = wb_q.setflags;
    assign writeback_flags     = wb_q.flags;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// tb/tb_memory_writeback_stage.sv - directed self-checking bench for memory_writeback_stage
module tb_memory_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic [63:0] ex_store_data;
    logic [3:0]  ex_flags;
    logic [4:0]  ex_write_addr;
    logic        ex_regwrite;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_setflags;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        writeback_regwrite;
    logic [4:0]  writeback_writeaddr;
    logic [63:0] writeback_writedata;
    logic        writeback_setflags;
    logic [3:0]  writeback_flags;
    logic        mem_fault;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_writeback_stage #(.MEM_TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_result          (ex_result),
        .ex_store_data      (ex_store_data),
        .ex_flags           (ex_flags),
        .ex_write_addr      (ex_write_addr),
        .ex_regwrite        (ex_regwrite),
        .ex_memwrite        (ex_memwrite),
        .ex_memtoreg        (ex_memtoreg),
        .ex_setflags        (ex_setflags),
        .stall              (stall),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack),
        .writeback_regwrite (writeback_regwrite),
        .writeback_writeaddr(writeback_writeaddr),
        .writeback_writedata(writeback_writedata),
        .writeback_setflags (writeback_setflags),
        .writeback_flags    (writeback_flags),
        .mem_fault          (mem_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [63:0] res, input logic [63:0] sd,
                          input logic [3:0] fl, input logic [4:0] wa, input logic rw,
                          input logic mw, input logic m2r, input logic sf);
        ex_valid = v; ex_result = res; ex_store_data = sd; ex_flags = fl;
        ex_write_addr = wa; ex_regwrite = rw; ex_memwrite = mw; ex_memtoreg = m2r; ex_setflags = sf;
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        set_ex(1'b1, 64'h40, 64'h99, 4'hF, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        step(); step(); step();
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb_rw", writeback_regwrite, 0);
        chk("rst_wb_data", writeback_writedata, 0);
        chk("rst_wb_sf", writeback_setflags, 0);
        chk("rst_fault", mem_fault, 0);

        // ALU op
        rst = 1'b1;
        set_ex(1'b1, 64'h1234, 64'h0, 4'b1010, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk("alu_rw", writeback_regwrite, 1);
        chk("alu_addr", writeback_writeaddr, 7);
        chk("alu_data", writeback_writedata, 64'h1234);
        chk("alu_sf", writeback_setflags, 1);
        chk("alu_flags", writeback_flags, 4'b1010);
        chk("alu_stall", stall, 0);
        ex_valid = 1'b0;
        step();
        chk("alu_rw_pulse", writeback_regwrite, 0);
        chk("alu_sf_pulse", writeback_setflags, 0);
        chk("alu_data_hold", writeback_writedata, 64'h1234);

        // Back-to-back ALU ops, register 0 passed through
        set_ex(1'b1, 64'hA, 64'h0, 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("b2b0_addr", writeback_writeaddr, 0);
        chk("b2b0_rw", writeback_regwrite, 1);
        set_ex(1'b1, 64'hB, 64'h0, 4'b0010, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("b2b1_data", writeback_writedata, 64'hB);
        chk("b2b1_rw", writeback_regwrite, 1);

        // Load, ack on the third MEM_WAIT edge
        set_ex(1'b1, 64'h100, 64'h0, 4'b0000, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("ld_req", mem_req, 1);
        chk("ld_we", mem_we, 0);
        chk("ld_addr", mem_addr, 64'h100);
        chk("ld_stall", stall, 1);
        chk("ld_accept_rw", writeback_regwrite, 0);
        step();
        chk("ld_wait1_req", mem_req, 1);
        step();
        chk("ld_wait2_stall", stall, 1);
        mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        step();
        mem_ack = 1'b0; ex_valid = 1'b0;
        chk("ld_rw", writeback_regwrite, 1);
        chk("ld_waddr", writeback_writeaddr, 3);
        chk("ld_data", writeback_writedata, 64'hDEAD_BEEF);
        chk("ld_stall_done", stall, 0);
        chk("ld_req_done", mem_req, 0);
        step();
        chk("ld_rw_pulse", writeback_regwrite, 0);

        // Store
        set_ex(1'b1, 64'h200, 64'h55, 4'b0101, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 64'h55);
        chk("st_addr", mem_addr, 64'h200);
        step();
        chk("st_hold_wdata", mem_wdata, 64'h55);
        chk("st_hold_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 64'h777;
        step();
        mem_ack = 1'b0; ex_valid = 1'b0;
        chk("st_rw", writeback_regwrite, 0);
        chk("st_sf", writeback_setflags, 1);
        chk("st_flags", writeback_flags, 4'b0101);
        chk("st_data", writeback_writedata, 0);

        // Ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_rw", writeback_regwrite, 0);
        chk("idle_ack_req", mem_req, 0);

        // Ack on the limit edge wins over timeout
        set_ex(1'b1, 64'h300, 64'h0, 4'b0000, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        step(); step(); step();
        chk("lim_pre_fault", mem_fault, 0);
        mem_ack = 1'b1; mem_rdata = 64'h1357;
        step();
        mem_ack = 1'b0; ex_valid = 1'b0;
        chk("lim_fault", mem_fault, 0);
        chk("lim_rw", writeback_regwrite, 1);
        chk("lim_data", writeback_writedata, 64'h1357);

        // Timeout; memwrite and memtoreg both set, store wins
        set_ex(1'b1, 64'h400, 64'h66, 4'b0000, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("to_we", mem_we, 1);
        step(); step(); step();
        chk("to_req_before", mem_req, 1);
        chk("to_fault_before", mem_fault, 0);
        step();
        chk("to_fault", mem_fault, 1);
        chk("to_req", mem_req, 0);
        chk("to_stall", stall, 1);
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        step();
        mem_ack = 1'b0;
        chk("to_late_ack_rw", writeback_regwrite, 0);
        chk("to_late_fault", mem_fault, 1);
        chk("to_late_stall", stall, 1);
        rst = 1'b0; ex_valid = 1'b0;
        step();
        rst = 1'b1;
        chk("to_rst_fault", mem_fault, 0);
        chk("to_rst_stall", stall, 0);

        // Reset mid-load, then a stale ack
        set_ex(1'b1, 64'h500, 64'h0, 4'b0000, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("mid_req", mem_req, 1);
        rst = 1'b0; ex_valid = 1'b0;
        step();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hF00D;
        step();
        mem_ack = 1'b0;
        chk("mid_rw", writeback_regwrite, 0);
        chk("mid_data", writeback_writedata, 0);
        chk("mid_stall", stall, 0);
        chk("mid_req_after", mem_req, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
